// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store over valid/ready, word RAM, fixed wait states.
// Optional alignment/size error detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_dest_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [31:0] rsp_dest_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, dest_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept, access, err, wr_en;

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane, eff_size;
    logic [31:0]       mem_word, shifted, load_data, wdata_sh;
    logic [15:0]       half;
    logic [3:0]        byte_en;

    // Upper address bits alias onto the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

    assign accept      = (state_q == StIdle) && req_valid_i;
    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign rsp_dest_o  = dest_q;

    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];
    assign mem_word = mem[word_idx];

`ifdef DMEM_ALIGN_CHECK_EN
    assign err = (size_q == 2'b11) || (size_q == 2'b01 && lane[0]) ||
                 (size_q == 2'b10 && lane != 2'b00);
    assign eff_size = size_q;
`else
    assign err      = 1'b0;
    assign eff_size = (size_q == 2'b11) ? 2'b10 : size_q;
`endif

    always_comb begin
        shifted  = mem_word >> {lane, 3'b000};
        half     = lane[1] ? mem_word[31:16] : mem_word[15:0];
        case (eff_size)
            2'b00: begin
                load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
                byte_en   = 4'b0001 << lane;
                wdata_sh  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                load_data = {{16{signed_q & half[15]}}, half};
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata_q[15:0]}};
            end
            default: begin
                load_data = mem_word;
                byte_en   = 4'b1111;
                wdata_sh  = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = StResp;
                    rdata_d = (we_q || err) ? 32'd0 : load_data;
                    err_d   = err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_en = access && we_q && !err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            dest_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q     <= req_we_i;
                signed_q <= req_signed_i;
                size_q   <= req_size_i;
                addr_q   <= req_addr_i[ADDR_W+1:0];
                wdata_q  <= req_wdata_i;
                dest_q   <= req_dest_i;
            end
        end
    end

    // RAM is deliberately not reset; a store interrupted by reset never reaches wr_en.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

    localparam int unsigned WS = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_dest;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata, rsp_dest;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(WS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_signed_i(req_signed),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_dest_i  (req_dest),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_dest_o  (rsp_dest),
        .rsp_err_o   (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_dest"},  rsp_dest,  32'd0);
        check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    endtask

    // One full transaction; hold keeps rsp_ready low that many cycles after rsp_valid rises.
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] dest, input logic [31:0] exp_rdata,
                       input logic exp_err, input int hold);
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_dest   = dest;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hxxxx_xxxx;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, WS + 1);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        check({tag, "_dest"}, rsp_dest, dest);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (hold > 0) begin
            check({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
            check({tag, "_post_req_ready"}, {31'd0, req_ready}, 32'd1);
        end
    endtask

    logic [31:0] exp_w10;
    logic        chk;

    initial begin
`ifdef DMEM_ALIGN_CHECK_EN
        chk = 1'b1;
`else
        chk = 1'b0;
`endif
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_dest   = 32'd0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        txn("st_w10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h8000_00FF, 32'h1, 32'h0, 1'b0, 0);
        txn("ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h2, 32'h8000_00FF, 1'b0, 0);
        txn("st_b13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AB, 32'h3, 32'h0, 1'b0, 0);
        txn("ld_sb13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h4, 32'hFFFF_FFAB, 1'b0, 0);
        txn("ld_ub13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h5, 32'h0000_00AB, 1'b0, 0);
        txn("ld_w10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h6, 32'hAB00_00FF, 1'b0, 0);
        txn("st_h22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 32'h7, 32'h0, 1'b0, 0);
        txn("ld_sh22", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h7, 32'hFFFF_8001, 1'b0, 0);
        txn("ld_uh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h8, 32'h0000_8001, 1'b0, 0);
        txn("ld_sb23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h9, 32'hFFFF_FF80, 1'b0, 0);
        txn("ld_ub22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'hA, 32'h0000_0001, 1'b0, 0);

        // Misaligned word accesses: error with checking, aliased to word 0x10 without.
        if (chk) begin
            txn("ld_w11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'hB, 32'h0, 1'b1, 0);
            txn("st_w11", 1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFF_FFFF, 32'hC, 32'h0, 1'b1, 0);
            txn("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hD, 32'h0, 1'b1, 0);
            exp_w10 = 32'hAB00_00FF;
        end else begin
            txn("ld_w11", 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'hB, 32'hAB00_00FF, 1'b0, 0);
            txn("st_w11", 1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFF_FFFF, 32'hC, 32'h0, 1'b0, 0);
            txn("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hD, 32'hFFFF_FFFF, 1'b0, 0);
            exp_w10 = 32'hFFFF_FFFF;
        end
        txn("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hE, exp_w10, 1'b0, 0);
        txn("stall",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hF, exp_w10, 1'b0, 5);

        // Reset while a store sits in WAIT must discard it.
        txn("st_w30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h1234_5678, 32'h10, 32'h0, 1'b0, 0);
        txn("ld_w30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11, 32'h1234_5678, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h30;
        req_wdata = 32'hDEAD_BEEF;
        req_dest  = 32'h12;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_req_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        txn("ld_w30b", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h13, 32'h1234_5678, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the load/store requests issued by the pipeline Memory stage. It accepts one request at a time over a valid/ready handshake and holds a word-organised on-chip RAM. After a configurable number of wait states it performs the access and returns sign- or zero-extended load data plus the destination tag over a second valid/ready handshake. Only one transaction is in flight at a time.

## Interface
- ADDR_W, 10: word-address bits; RAM holds 2^ADDR_W 32-bit words (byte address bits [ADDR_W+1:0] used, upper bits ignored/aliased)
- WAIT_STATES, 1: extra cycles between acceptance and access, 0..15

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept; high only in IDLE
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed_i  in  1  loads: 1 sign-extend, 0 zero-extend
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_dest_i  in  32  destination tag, returned unchanged
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes response
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_dest_o  out  32  latched req_dest_i
- rsp_err_o  out  1  misaligned or illegal-size access

## Operation
- FSM states IDLE, WAIT, RESP; reset state IDLE.
- IDLE: req_ready_o=1. On req_valid_i: latch we/size/signed/addr/wdata/dest. Load wait counter with WAIT_STATES. Go to WAIT, or to ACCESS-then-RESP directly when WAIT_STATES=0.
- WAIT: counter decrements each cycle. When it reaches 0, perform the access in that cycle and go to RESP.
- Access, little-endian:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Store: writes only the addressed byte lanes; other bytes are unchanged.
  - Load: extracts the lane and extends per req_signed_i.
- Error (with macro): half with addr[0]=1, word with addr[1:0]≠00, or size 11. Effect: no RAM write, rsp_rdata_o=0, rsp_err_o=1.
- RESP: rsp_valid_o=1 and the data/dest/err outputs are stable until rsp_valid_o && rsp_ready_i. Then go to IDLE.
- Reset:
  - Clears the FSM and all registered outputs.
  - An unperformed store is discarded; a pending response is dropped.
  - RAM contents are not reset (undefined until written).

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_dest_o=0, rsp_err_o=0.
- Acceptance at edge N gives rsp_valid_o high after edge N+1+WAIT_STATES. The RAM write takes effect at that same edge.
- With rsp_ready_i held high, throughput is one transaction per WAIT_STATES+3 cycles: the response-handshake edge returns to IDLE, and the next request is accepted one edge later.
- req_ready_o is a decode of state only, with no combinational path from req_valid_i. Request inputs are don't-care outside IDLE.
- A load issued after a store to the same address returns the new data.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: error detection as above.
- DMEM_ALIGN_CHECK_EN undefined:
  - rsp_err_o is constant 0.
  - Size 11 is treated as word.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - Every access is performed.

## Test plan
- Reset, then store word 0x8000_00FF at 0x10, then load word 0x10: rsp_rdata_o=0x8000_00FF, rsp_err_o=0, rsp_valid_o rises WAIT_STATES+1 edges after acceptance.
- Store byte 0xAB to 0x13, then load signed byte at 0x13 → 0xFFFF_FFAB; unsigned → 0x0000_00AB; load word 0x10 → 0xAB00_00FF.
- Store half 0x8001 to 0x22, then load signed half 0x22 → 0xFFFF_8001; rsp_dest_o echoes the request tag 0x0000_0007.
- With macro: load word at 0x11 → rsp_err_o=1, rsp_rdata_o=0. A store of 0xFFFF_FFFF at 0x11 leaves word 0x10 unchanged. Without macro: the load at 0x11 returns the word at 0x10 with rsp_err_o=0.
- Hold rsp_ready_i=0 for 5 cycles: rsp_valid_o and the data stay stable and req_ready_o=0. Release: the handshake completes, and req_ready_o=1 on the next cycle.
- Assert rst_n=0 during WAIT of a store to 0x30 (previously 0x1234_5678): outputs return to reset values, and a later load of 0x30 returns 0x1234_5678.
